dev_bus_bridge: RTL and testbench

Wishbone-responder to device-bus-initiator bridge between the Caravel management-core Wishbone port and the user-project peripherals. It decodes each Wishbone cycle to one of `NDEV` device slots and drives that slot's `stb/rw/addr/dwrite` request. It then waits for the device `ack`, returns `dtr` on the Wishbone side, and terminates unanswered or undecodable cycles with an error pattern. The bridge is the initiator end of the device bus that peripherals such as the GPIO block respond on.

---
 rtl/dev_bus_bridge_pkg.sv | 25 ++
 rtl/bus_timeout_ctr.sv | 25 ++
 rtl/dev_bus_bridge.sv | 149 ++++++++++++++
 tb/tb_dev_bus_bridge.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dev_bus_bridge_pkg.sv
// Shared definitions for the Wishbone-to-device-bus bridge: FSM encoding,
// error data pattern and address field positions.
package dev_bus_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RESP = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } bus_state_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  localparam int SLOT_LSB = 8;
  localparam int SLOT_MSB = 11;
  localparam int REG_LSB  = 2;
  localparam int REG_MSB  = 4;

  // Writes without all byte lanes enabled are acknowledged but never reach a device.
  function automatic logic is_partial_write(input logic we, input logic [3:0] sel);
    return we && (sel != 4'hF);
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Cycle counter bounding how long the bridge waits in REQ for a device ack.
module bus_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [7:0] count_r;

  // Clear and enable together restart the count at one so the entry cycle is included.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 8'd0;
    end else begin
      count_r <= (clear ? 8'd0 : count_r) + (en ? 8'd1 : 8'd0);
    end
  end

  assign expired = (count_r == 8'(TIMEOUT));

endmodule

// File: rtl/dev_bus_bridge.sv
// Wishbone responder that forwards each decoded cycle to one device slot and
// returns its data, or terminates it with an error pattern.
module dev_bus_bridge
  import dev_bus_bridge_pkg::*;
#(
  parameter int          NDEV    = 4,
  parameter logic [15:0] BASE    = 16'h3000,
  parameter int          TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [NDEV-1:0]    dev_stb,
  output logic               dev_rw,
  output logic [2:0]         dev_addr,
  output logic [31:0]        dev_dwrite,
  input  logic [NDEV-1:0]    dev_ack,
  input  logic [32*NDEV-1:0] dev_dtr,
  output logic               bus_err
);

  localparam logic [4:0] NDEV_W = 5'(NDEV);

  bus_state_t      state_r;
  bus_state_t      next_s;
  logic [3:0]      slot_r;
  logic [3:0]      slot_in_s;
  logic [3:0]      slot_mux_s;
  logic            start_s;
  logic            hit_s;
  logic            latch_s;
  logic            ack_sel_s;
  logic            tmo_en_s;
  logic            expired_s;
  logic [31:0]     rd_data_s;
  logic [NDEV-1:0] stb_next_s;
  logic            unused_adr_s;

  assign slot_in_s    = wbs_adr_i[SLOT_MSB:SLOT_LSB];
  assign start_s      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign hit_s        = (wbs_adr_i[31:16] == BASE) && ({1'b0, slot_in_s} < NDEV_W);
  assign slot_mux_s   = latch_s ? slot_in_s : slot_r;
  assign tmo_en_s     = latch_s | ((state_r == ST_REQ) & ~ack_sel_s);
  assign unused_adr_s = ^{wbs_adr_i[15:12], wbs_adr_i[7:5], wbs_adr_i[1:0]};

  // Per-slot selection of read data, ack and next strobe pattern.
  always_comb begin
    rd_data_s  = 32'd0;
    ack_sel_s  = 1'b0;
    stb_next_s = {NDEV{1'b0}};
    for (int i = 0; i < NDEV; i++) begin
      rd_data_s     = rd_data_s | (dev_dtr[32*i +: 32] & {32{slot_r == 4'(i)}});
      ack_sel_s     = ack_sel_s | (dev_ack[i] & (slot_r == 4'(i)));
      stb_next_s[i] = (slot_mux_s == 4'(i));
    end
  end

  // Next-state decode for the transaction FSM.
  always_comb begin
    next_s  = state_r;
    latch_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!start_s) begin
          next_s = ST_IDLE;
        end else if (!hit_s) begin
          next_s = ST_ERR;
        end else if (is_partial_write(wbs_we_i, wbs_sel_i)) begin
          next_s = ST_DONE;
        end else begin
          next_s  = ST_REQ;
          latch_s = 1'b1;
        end
      end
      ST_REQ: begin
        if (ack_sel_s) begin
          next_s = ST_RESP;
        end else if (expired_s) begin
          next_s = ST_ERR;
        end else begin
          next_s = ST_REQ;
        end
      end
      ST_RESP: next_s = ST_IDLE;
      ST_DONE: next_s = ST_IDLE;
      ST_ERR:  next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (latch_s),
    .en      (tmo_en_s),
    .expired (expired_s)
  );

  // State register and Wishbone-side outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      bus_err   <= 1'b0;
      dev_stb   <= {NDEV{1'b0}};
    end else begin
      state_r   <= next_s;
      wbs_ack_o <= (next_s == ST_RESP) || (next_s == ST_DONE) || (next_s == ST_ERR);
      bus_err   <= (next_s == ST_ERR);
      dev_stb   <= (next_s == ST_REQ) ? stb_next_s : {NDEV{1'b0}};
      case (next_s)
        ST_RESP: wbs_dat_o <= dev_rw ? 32'd0 : rd_data_s;
        ST_ERR:  wbs_dat_o <= BUS_ERR_DATA;
        default: wbs_dat_o <= 32'd0;
      endcase
    end
  end

  // Request fields are captured on REQ entry and held until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_r     <= 4'd0;
      dev_rw     <= 1'b0;
      dev_addr   <= 3'd0;
      dev_dwrite <= 32'd0;
    end else if (latch_s) begin
      slot_r     <= slot_in_s;
      dev_rw     <= wbs_we_i;
      dev_addr   <= wbs_adr_i[REG_MSB:REG_LSB];
      dev_dwrite <= wbs_dat_i;
    end else begin
      slot_r     <= slot_r;
      dev_rw     <= dev_rw;
      dev_addr   <= dev_addr;
      dev_dwrite <= dev_dwrite;
    end
  end

endmodule

// File: tb/tb_dev_bus_bridge.sv
// Directed self-checking bench for dev_bus_bridge with a programmable-latency
// device model on every slot.
module tb_dev_bus_bridge;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wbs_stb_i = 1'b0;
  logic         wbs_cyc_i = 1'b0;
  logic         wbs_we_i = 1'b0;
  logic [3:0]   wbs_sel_i = 4'h0;
  logic [31:0]  wbs_adr_i = 32'd0;
  logic [31:0]  wbs_dat_i = 32'd0;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [3:0]   dev_stb;
  logic         dev_rw;
  logic [2:0]   dev_addr;
  logic [31:0]  dev_dwrite;
  logic [3:0]   dev_ack;
  logic [127:0] dev_dtr;
  logic         bus_err;

  int n_tests = 0;
  int n_fail  = 0;
  int wait_cfg = 0;
  logic never_ack = 1'b0;
  int wait_cnt = 0;
  int stb_cycles;
  int ack_cycles;

  always #5 clk = ~clk;

  dev_bus_bridge #(.NDEV(4), .BASE(16'h3000), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .dev_stb(dev_stb), .dev_rw(dev_rw), .dev_addr(dev_addr), .dev_dwrite(dev_dwrite),
    .dev_ack(dev_ack), .dev_dtr(dev_dtr), .bus_err(bus_err)
  );

  // Device model: each slot acks after wait_cfg strobed cycles (0 = same cycle).
  assign dev_dtr = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_00A5};
  assign dev_ack = (!never_ack && dev_stb != 4'd0 && wait_cnt >= wait_cfg) ? dev_stb : 4'd0;

  always @(posedge clk) begin
    if (dev_stb == 4'd0) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
  endtask

  task automatic release_bus();
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_stb", 32'(dev_stb), 32'd0);
    check("rst_rw", 32'(dev_rw), 32'd0);
    check("rst_addr", 32'(dev_addr), 32'd0);
    check("rst_dwrite", dev_dwrite, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    reset = 1'b0;
    tick();

    // Zero-wait read, slot 0 register 2
    start(1'b0, 32'h3000_0008, 32'd0, 4'hF);
    tick();
    check("rd0_stb", 32'(dev_stb), 32'h1);
    check("rd0_addr", 32'(dev_addr), 32'd2);
    check("rd0_rw", 32'(dev_rw), 32'd0);
    check("rd0_ack_c1", 32'(wbs_ack_o), 32'd0);
    tick();
    check("rd0_ack", 32'(wbs_ack_o), 32'd1);
    check("rd0_dat", wbs_dat_o, 32'h0000_00A5);
    check("rd0_stb_after", 32'(dev_stb), 32'd0);
    check("rd0_err", 32'(bus_err), 32'd0);
    release_bus();
    tick();
    check("rd0_ack_width", 32'(wbs_ack_o), 32'd0);

    // Full write to slot 1 register 1
    start(1'b1, 32'h3000_0104, 32'h1234_5678, 4'hF);
    tick();
    check("wr_stb", 32'(dev_stb), 32'h2);
    check("wr_rw", 32'(dev_rw), 32'd1);
    check("wr_addr", 32'(dev_addr), 32'd1);
    check("wr_dwrite", dev_dwrite, 32'h1234_5678);
    tick();
    check("wr_stb_1cyc", 32'(dev_stb), 32'd0);
    check("wr_ack", 32'(wbs_ack_o), 32'd1);
    check("wr_dat", wbs_dat_o, 32'd0);
    release_bus();
    tick();

    // Three wait cycles, with cyc dropped mid-transaction
    wait_cfg = 3;
    start(1'b0, 32'h3000_0200, 32'd0, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) wbs_cyc_i = 1'b0;
      check("wait_stb", 32'(dev_stb), 32'h4);
      check("wait_noack", 32'(wbs_ack_o), 32'd0);
    end
    tick();
    check("wait_ack", 32'(wbs_ack_o), 32'd1);
    check("wait_dat", wbs_dat_o, 32'h2222_0002);
    release_bus();
    wait_cfg = 0;
    tick();

    // Device never answers: 15 REQ cycles then error termination
    never_ack = 1'b1;
    start(1'b0, 32'h3000_030C, 32'd0, 4'hF);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("tmo_stb", 32'(dev_stb), 32'h8);
      check("tmo_noack", 32'(wbs_ack_o), 32'd0);
    end
    tick();
    check("tmo_ack", 32'(wbs_ack_o), 32'd1);
    check("tmo_dat", wbs_dat_o, 32'hDEAD_BEEF);
    check("tmo_err", 32'(bus_err), 32'd1);
    check("tmo_stb_off", 32'(dev_stb), 32'd0);
    release_bus();
    tick();
    check("tmo_ack_end", 32'(wbs_ack_o), 32'd0);
    check("tmo_err_end", 32'(bus_err), 32'd0);
    never_ack = 1'b0;

    // Base mismatch
    start(1'b0, 32'h4000_0000, 32'd0, 4'hF);
    tick();
    check("miss1_stb", 32'(dev_stb), 32'd0);
    check("miss1_ack", 32'(wbs_ack_o), 32'd1);
    check("miss1_dat", wbs_dat_o, 32'hDEAD_BEEF);
    check("miss1_err", 32'(bus_err), 32'd1);
    release_bus();
    tick();

    // Slot beyond NDEV
    start(1'b0, 32'h3000_0500, 32'd0, 4'hF);
    tick();
    check("miss2_stb", 32'(dev_stb), 32'd0);
    check("miss2_ack", 32'(wbs_ack_o), 32'd1);
    check("miss2_dat", wbs_dat_o, 32'hDEAD_BEEF);
    release_bus();
    tick();

    // Partial write is acked without a strobe
    start(1'b1, 32'h3000_0000, 32'hFFFF_FFFF, 4'h3);
    tick();
    check("pw_stb", 32'(dev_stb), 32'd0);
    check("pw_ack", 32'(wbs_ack_o), 32'd1);
    check("pw_dat", wbs_dat_o, 32'd0);
    check("pw_err", 32'(bus_err), 32'd0);
    release_bus();
    tick();

    // Reset while in REQ
    never_ack = 1'b1;
    start(1'b1, 32'h3000_0114, 32'hCAFE_0001, 4'hF);
    tick();
    check("rreq_stb", 32'(dev_stb), 32'h2);
    reset = 1'b1;
    release_bus();
    tick();
    check("rreq_stb_off", 32'(dev_stb), 32'd0);
    check("rreq_ack", 32'(wbs_ack_o), 32'd0);
    check("rreq_rw", 32'(dev_rw), 32'd0);
    check("rreq_addr", 32'(dev_addr), 32'd0);
    check("rreq_dwrite", dev_dwrite, 32'd0);
    reset = 1'b0;
    never_ack = 1'b0;
    tick();

    // Back-to-back reads with stb held: one strobe cycle per ack
    stb_cycles = 0;
    ack_cycles = 0;
    start(1'b0, 32'h3000_0000, 32'd0, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (dev_stb != 4'd0) stb_cycles++;
      if (wbs_ack_o) ack_cycles++;
    end
    check("b2b_stb_cnt", 32'(stb_cycles), 32'd4);
    check("b2b_ack_cnt", 32'(ack_cycles), 32'd4);
    release_bus();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
